apb_cmd_master: RTL and testbench
=================================

APB_CMD_MASTER -- requirements
Module: apb_cmd_master

Interface
REQ-001 Parameter ADDR_W, default 32, APB address width.
REQ-002 Parameter DATA_W, default 32, APB data width; multiple of 8.
REQ-003 Parameter DEPTH, default 4, entries in each of the command and response FIFOs; power of 2, ≥2.
REQ-004 Parameter TIMEOUT, default 16, ACCESS cycles without PREADY before abort; ≥2.
REQ-005 The block SHALL have one clock and an asynchronous, active-low reset:
- PCLK  in  1  clock; all state updates on its rising edge.
- PRESETn  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command FIFO not full.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_W  transfer address.
- cmd_wdata  in  DATA_W  write data.
- cmd_strb  in  DATA_W/8  write byte strobes.
- rsp_valid  out  1  response FIFO not empty.
- rsp_ready  in  1  response consumed.
- rsp_rdata  out  DATA_W  read data; 0 for writes.
- rsp_err  out  1  PSLVERR or timeout.
- rsp_timeout  out  1  transfer aborted by timeout.
- busy  out  1  FSM not IDLE or command FIFO non-empty.
- PSEL, PENABLE, PWRITE  out  1  APB control.
- PADDR  out  ADDR_W; PWDATA  out  DATA_W; PSTRB  out  DATA_W/8.
- PRDATA  in  DATA_W; PREADY  in  1; PSLVERR  in  1.

Function
REQ-006 A command SHALL be pushed on a cycle where cmd_valid && cmd_ready; a response SHALL be popped on a cycle where rsp_valid && rsp_ready; both FIFOs are first-in first-out with wrap-around pointers.
REQ-007 The FSM SHALL use the states IDLE, SETUP and ACCESS; all APB outputs are registered.
- Launch condition: command FIFO non-empty, and response FIFO occupancy after this cycle's push/pop < DEPTH.
REQ-008 In IDLE, when the launch condition holds, the FSM SHALL pop the head command, drive PSEL=1, PENABLE=0 and PADDR/PWRITE/PWDATA/PSTRB from that command, and go to SETUP; PSTRB SHALL be 0 for reads.
REQ-009 In SETUP, the FSM SHALL set PENABLE=1 and go to ACCESS; the address, control and data outputs SHALL remain stable.
REQ-010 In ACCESS with PREADY=1, the FSM SHALL push a response {rdata = PRDATA for reads else 0, err = PSLVERR, timeout = 0}.
- If the launch condition holds: go directly to SETUP with the next command (PSEL stays 1, PENABLE=0).
- Otherwise: go to IDLE with PSEL=0, PENABLE=0.
REQ-011 In ACCESS with PREADY=0, a wait counter SHALL increment.
- When the counter reaches TIMEOUT-1, the next edge aborts the transfer: PSEL=0, PENABLE=0, push a response {rdata = 0, err = 1, timeout = 1}, go to IDLE.
- The counter SHALL clear on entry to SETUP.
REQ-012 Latency: from an empty, idle block, a command accepted at edge 0 SHALL give PSEL=1 after edge 1 and PENABLE=1 after edge 2; with PREADY=1, rsp_valid=1 after edge 3.
REQ-013 A simultaneous push and pop on a full FIFO SHALL be allowed for the response FIFO and SHALL NOT be allowed for the command FIFO (cmd_ready=0 when full); a push and pop on the same edge SHALL leave the occupancy unchanged.
REQ-014 When the response FIFO is full, the FSM SHALL NOT launch; a transfer already in flight SHALL complete, because a slot is reserved by the launch condition.
REQ-015 PADDR, PWRITE, PWDATA and PSTRB SHALL hold their last values while PSEL=0.

Reset
REQ-016 While PRESETn=0, the outputs SHALL be: PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, PSTRB=0, cmd_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, rsp_timeout=0, busy=0; the FSM SHALL be in IDLE and both FIFOs empty.
REQ-017 cmd_ready SHALL be 1 from the first edge after reset deassertion.
REQ-018 Reset asserted mid-transfer SHALL immediately drop PSEL and PENABLE and discard all queued commands and responses, with no response emitted.

Verification
REQ-019 Write 0x10←0xDEADBEEF, strb 0xF, PREADY=1 -> PSEL@1, PENABLE@2, PSTRB=0xF, rsp {0,0,0}@3.
REQ-020 Four back-to-back reads, PREADY=1, PRDATA=addr+1 -> no idle cycle between transfers (SETUP follows ACCESS directly), responses in order with rdata=addr+1.
REQ-021 Read, PREADY held 0 (TIMEOUT=16) -> abort after 16 ACCESS cycles, rsp {0,1,1}, PSEL=0; the next command proceeds normally.
REQ-022 Write with PREADY=1, PSLVERR=1 -> rsp_err=1, rsp_timeout=0.
REQ-023 rsp_ready=0, push 8 commands (DEPTH=4) -> 4 transfers complete, no further launch, cmd_ready=0 after the FIFO fills; raise rsp_ready -> the rest drain in order.
REQ-024 PRESETn pulsed low during ACCESS of a 3-command burst -> PSEL/PENABLE=0 immediately, rsp_valid=0, busy=0, no later APB activity.

Source files
------------

// File: rtl/apb_cmd_master_if.sv
// APB requester-side bus bundle for apb_cmd_master.
// The master modport is the requester; the slave modport is the completer.
interface apb_cmd_master_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                PSEL;
    logic                PENABLE;
    logic                PWRITE;
    logic [ADDR_W-1:0]   PADDR;
    logic [DATA_W-1:0]   PWDATA;
    logic [DATA_W/8-1:0] PSTRB;
    logic [DATA_W-1:0]   PRDATA;
    logic                PREADY;
    logic                PSLVERR;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apb_cmd_master.sv
// APB requester fed by a command FIFO.
// Each transfer returns exactly one entry through a response FIFO.
module apb_cmd_master #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                PCLK,
    input  logic                PRESETn,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_write,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [DATA_W-1:0]   cmd_wdata,
    input  logic [DATA_W/8-1:0] cmd_strb,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
    output logic                rsp_timeout,
    output logic                busy,
    apb_cmd_master_if.master    apb
);
    localparam int SW    = DATA_W / 8;
    localparam int PW    = $clog2(DEPTH);
    localparam int CW    = PW + 1;
    localparam int LW    = CW + 1;
    localparam int TW    = $clog2(TIMEOUT);
    localparam int CMD_W = 1 + ADDR_W + DATA_W + SW;
    localparam int RSP_W = DATA_W + 2;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t            state_q, state_d;
    logic [CMD_W-1:0]  cmd_mem [DEPTH];
    logic [RSP_W-1:0]  rsp_mem [DEPTH];
    logic [PW-1:0]     cmd_wr_ptr, cmd_rd_ptr, rsp_wr_ptr, rsp_rd_ptr;
    logic [CW-1:0]     cmd_count, rsp_count;
    logic              ready_en;
    logic [TW-1:0]     wait_q, wait_d;

    logic              psel_q, psel_d, penable_q, penable_d, pwrite_q, pwrite_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;
    logic [SW-1:0]     pstrb_q, pstrb_d;

    logic              head_write;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_wdata;
    logic [SW-1:0]     head_strb;

    logic              cmd_push, rsp_pop, rsp_push, launch, launch_ok;
    logic              access_done, access_abort;
    logic [DATA_W-1:0] rd_val;
    logic [RSP_W-1:0]  rsp_push_data;
    logic [LW-1:0]     rsp_level_next;

    assign {head_write, head_addr, head_wdata, head_strb} = cmd_mem[cmd_rd_ptr];

    assign cmd_ready = ready_en && (cmd_count != CW'(DEPTH));
    assign cmd_push  = cmd_valid && cmd_ready;
    assign rsp_valid = (rsp_count != '0);
    assign rsp_pop   = rsp_valid && rsp_ready;
    assign busy      = (state_q != IDLE) || (cmd_count != '0);

    assign access_done   = (state_q == ACCESS) && apb.PREADY;
    assign access_abort  = (state_q == ACCESS) && !apb.PREADY && (wait_q == TW'(TIMEOUT - 1));
    assign rsp_push      = access_done || access_abort;
    assign rd_val        = pwrite_q ? '0 : apb.PRDATA;
    assign rsp_push_data = access_abort ? {{DATA_W{1'b0}}, 2'b11}
                                        : {rd_val, apb.PSLVERR, 1'b0};

    // A launch reserves a response slot, so an in-flight transfer can always retire.
    assign rsp_level_next = LW'(rsp_count) + LW'(rsp_push) - LW'(rsp_pop);
    assign launch_ok      = (cmd_count != '0) && (rsp_level_next < LW'(DEPTH));

    always_comb begin
        state_d   = state_q;
        psel_d    = psel_q;
        penable_d = penable_q;
        pwrite_d  = pwrite_q;
        paddr_d   = paddr_q;
        pwdata_d  = pwdata_q;
        pstrb_d   = pstrb_q;
        wait_d    = wait_q;
        launch    = 1'b0;
        unique case (state_q)
            IDLE: begin
                launch = launch_ok;
            end
            SETUP: begin
                penable_d = 1'b1;
                state_d   = ACCESS;
            end
            ACCESS: begin
                if (apb.PREADY) begin
                    launch = launch_ok;
                    if (!launch_ok) begin
                        psel_d    = 1'b0;
                        penable_d = 1'b0;
                        state_d   = IDLE;
                    end
                end else if (access_abort) begin
                    psel_d    = 1'b0;
                    penable_d = 1'b0;
                    state_d   = IDLE;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (launch) begin
            state_d   = SETUP;
            psel_d    = 1'b1;
            penable_d = 1'b0;
            pwrite_d  = head_write;
            paddr_d   = head_addr;
            pwdata_d  = head_wdata;
            pstrb_d   = head_write ? head_strb : '0;
            wait_d    = '0;
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q   <= IDLE;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            pstrb_q   <= '0;
            wait_q    <= '0;
        end else begin
            state_q   <= state_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            pwrite_q  <= pwrite_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
            pstrb_q   <= pstrb_d;
            wait_q    <= wait_d;
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            ready_en   <= 1'b0;
            cmd_wr_ptr <= '0;
            cmd_rd_ptr <= '0;
            cmd_count  <= '0;
            rsp_wr_ptr <= '0;
            rsp_rd_ptr <= '0;
            rsp_count  <= '0;
        end else begin
            ready_en <= 1'b1;
            if (cmd_push) cmd_wr_ptr <= cmd_wr_ptr + 1'b1;
            if (launch)   cmd_rd_ptr <= cmd_rd_ptr + 1'b1;
            if (rsp_push) rsp_wr_ptr <= rsp_wr_ptr + 1'b1;
            if (rsp_pop)  rsp_rd_ptr <= rsp_rd_ptr + 1'b1;
            cmd_count <= cmd_count + CW'(cmd_push) - CW'(launch);
            rsp_count <= rsp_count + CW'(rsp_push) - CW'(rsp_pop);
        end
    end

    always_ff @(posedge PCLK) begin
        if (cmd_push) cmd_mem[cmd_wr_ptr] <= {cmd_write, cmd_addr, cmd_wdata, cmd_strb};
        if (rsp_push) rsp_mem[rsp_wr_ptr] <= rsp_push_data;
    end

    assign {rsp_rdata, rsp_err, rsp_timeout} = rsp_valid ? rsp_mem[rsp_rd_ptr] : '0;

    assign apb.PSEL    = psel_q;
    assign apb.PENABLE = penable_q;
    assign apb.PWRITE  = pwrite_q;
    assign apb.PADDR   = paddr_q;
    assign apb.PWDATA  = pwdata_q;
    assign apb.PSTRB   = pstrb_q;
endmodule

// File: tb/tb_apb_cmd_master.sv
// Directed bench for apb_cmd_master with a tiny APB completer (PRDATA = PADDR + 1)
// and an in-order response scoreboard.
module tb_apb_cmd_master;
    logic        PCLK = 1'b0;
    logic        PRESETn;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [3:0]  cmd_strb;
    logic        rsp_valid, rsp_ready, rsp_err, rsp_timeout, busy;
    logic [31:0] rsp_rdata;
    logic        ready_ctl, err_ctl;

    int          total = 0;
    int          bad = 0;
    int          rise_cnt = 0;
    int          setup_cnt = 0;
    int          access_cnt = 0;
    logic        psel_prev = 1'b0;
    logic [33:0] exp_q [$];

    always #5 PCLK = ~PCLK;

    apb_cmd_master_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    assign bus.PREADY  = ready_ctl;
    assign bus.PSLVERR = err_ctl;
    assign bus.PRDATA  = bus.PADDR + 32'h1;

    apb_cmd_master #(.ADDR_W(32), .DATA_W(32), .DEPTH(4), .TIMEOUT(16)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout), .busy(busy),
        .apb(bus)
    );

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    // Offers one command and returns just after the edge that accepted it.
    task automatic applyStimulus(input logic w, input logic [31:0] a, input logic [31:0] d,
                                 input logic [3:0] s);
        int n = 0;
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        cmd_strb  = s;
        while (!cmd_ready && n < 200) begin
            tick();
            n++;
        end
        if (!cmd_ready) checkOutput("cmd_accept_wait", 64'(cmd_ready), 64'd1);
        else tick();
        cmd_valid = 1'b0;
    endtask

    task automatic waitIdle();
        int n = 0;
        while ((busy || rsp_valid || bus.PSEL) && n < 300) begin
            tick();
            n++;
        end
        if (n >= 300) checkOutput("idle_wait", 64'(busy), 64'd0);
    endtask

    always @(negedge PCLK) begin
        if (PRESETn) begin
            if (bus.PSEL && !psel_prev)       rise_cnt++;
            if (bus.PSEL && !bus.PENABLE)     setup_cnt++;
            if (bus.PSEL && bus.PENABLE)      access_cnt++;
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) checkOutput("rsp_unexpected", 64'(exp_q.size()), 64'd1);
                else checkOutput("rsp", 64'({rsp_rdata, rsp_err, rsp_timeout}), 64'(exp_q.pop_front()));
            end
        end
        psel_prev = bus.PSEL;
    end

    initial begin
        PRESETn   = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        cmd_strb  = '0;
        rsp_ready = 1'b0;
        ready_ctl = 1'b1;
        err_ctl   = 1'b0;

        repeat (3) tick();
        checkOutput("rst_psel",      64'(bus.PSEL), 64'd0);
        checkOutput("rst_penable",   64'(bus.PENABLE), 64'd0);
        checkOutput("rst_paddr",     64'(bus.PADDR), 64'd0);
        checkOutput("rst_pstrb",     64'(bus.PSTRB), 64'd0);
        checkOutput("rst_cmd_ready", 64'(cmd_ready), 64'd0);
        checkOutput("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        checkOutput("rst_busy",      64'(busy), 64'd0);
        PRESETn = 1'b1;
        tick();
        checkOutput("cmd_ready_after_rst", 64'(cmd_ready), 64'd1);

        // Single write: latency and field checks with the response held.
        applyStimulus(1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
        checkOutput("w_psel_e0", 64'(bus.PSEL), 64'd0);
        tick();
        checkOutput("w_psel_e1",    64'(bus.PSEL), 64'd1);
        checkOutput("w_penable_e1", 64'(bus.PENABLE), 64'd0);
        checkOutput("w_paddr",      64'(bus.PADDR), 64'h10);
        checkOutput("w_pwrite",     64'(bus.PWRITE), 64'd1);
        checkOutput("w_pwdata",     64'(bus.PWDATA), 64'hDEADBEEF);
        checkOutput("w_pstrb",      64'(bus.PSTRB), 64'hF);
        tick();
        checkOutput("w_penable_e2", 64'(bus.PENABLE), 64'd1);
        checkOutput("w_paddr_e2",   64'(bus.PADDR), 64'h10);
        tick();
        checkOutput("w_rsp_valid_e3", 64'(rsp_valid), 64'd1);
        checkOutput("w_rsp_e3", 64'({rsp_rdata, rsp_err, rsp_timeout}), 64'd0);
        checkOutput("w_psel_e3", 64'(bus.PSEL), 64'd0);
        checkOutput("w_paddr_hold",  64'(bus.PADDR), 64'h10);
        checkOutput("w_pwrite_hold", 64'(bus.PWRITE), 64'd1);
        exp_q.push_back({32'h0, 1'b0, 1'b0});
        rsp_ready = 1'b1;
        tick();
        checkOutput("w_rsp_popped", 64'(rsp_valid), 64'd0);

        // Four back-to-back reads must chain SETUP directly after ACCESS.
        rise_cnt  = 0;
        setup_cnt = 0;
        for (int i = 1; i <= 4; i++) exp_q.push_back({32'(i * 256 + 1), 1'b0, 1'b0});
        for (int i = 1; i <= 4; i++) applyStimulus(1'b0, 32'(i * 256), 32'h0, 4'hF);
        waitIdle();
        checkOutput("b2b_psel_rises", 64'(rise_cnt), 64'd1);
        checkOutput("b2b_setups",     64'(setup_cnt), 64'd4);

        // Read that never gets PREADY: abort after 16 ACCESS cycles.
        ready_ctl  = 1'b0;
        access_cnt = 0;
        exp_q.push_back({32'h0, 1'b1, 1'b1});
        applyStimulus(1'b0, 32'h40, 32'h0, 4'hF);
        tick();
        checkOutput("to_psel",       64'(bus.PSEL), 64'd1);
        checkOutput("to_pstrb_read", 64'(bus.PSTRB), 64'd0);
        waitIdle();
        checkOutput("to_access_cycles", 64'(access_cnt), 64'd16);
        checkOutput("to_psel_after",    64'(bus.PSEL), 64'd0);
        ready_ctl = 1'b1;
        exp_q.push_back({32'h81, 1'b0, 1'b0});
        applyStimulus(1'b0, 32'h80, 32'h0, 4'h0);
        waitIdle();

        // Slave error on a write.
        err_ctl = 1'b1;
        exp_q.push_back({32'h0, 1'b1, 1'b0});
        applyStimulus(1'b1, 32'h20, 32'h1234, 4'h3);
        waitIdle();
        err_ctl = 1'b0;

        // Response FIFO full: four transfers complete, then launches stall.
        rsp_ready = 1'b0;
        setup_cnt = 0;
        for (int i = 0; i < 8; i++) exp_q.push_back({32'(32'h1000 + i * 16 + 1), 1'b0, 1'b0});
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, 32'(32'h1000 + i * 16), 32'h0, 4'hF);
        repeat (20) tick();
        checkOutput("full_setups",    64'(setup_cnt), 64'd4);
        checkOutput("full_cmd_ready", 64'(cmd_ready), 64'd0);
        checkOutput("full_rsp_valid", 64'(rsp_valid), 64'd1);
        checkOutput("full_psel",      64'(bus.PSEL), 64'd0);
        checkOutput("full_busy",      64'(busy), 64'd1);
        rsp_ready = 1'b1;
        waitIdle();
        checkOutput("drain_setups", 64'(setup_cnt), 64'd8);

        // Reset pulse in the middle of a stalled three-command burst.
        ready_ctl = 1'b0;
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 32'(32'h2000 + i * 4), 32'(i), 4'hF);
        begin
            int n = 0;
            while (!(bus.PSEL && bus.PENABLE) && n < 50) begin
                tick();
                n++;
            end
            if (n >= 50) checkOutput("mid_access_wait", 64'(bus.PENABLE), 64'd1);
        end
        #2 PRESETn = 1'b0;
        #1;
        checkOutput("mid_rst_psel",      64'(bus.PSEL), 64'd0);
        checkOutput("mid_rst_penable",   64'(bus.PENABLE), 64'd0);
        checkOutput("mid_rst_rsp_valid", 64'(rsp_valid), 64'd0);
        checkOutput("mid_rst_busy",      64'(busy), 64'd0);
        repeat (2) tick();
        PRESETn   = 1'b1;
        ready_ctl = 1'b1;
        rise_cnt  = 0;
        repeat (20) tick();
        checkOutput("post_rst_no_apb", 64'(rise_cnt), 64'd0);
        checkOutput("post_rst_rsp",    64'(rsp_valid), 64'd0);
        checkOutput("post_rst_busy",   64'(busy), 64'd0);
        checkOutput("rsp_left", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation did not finish, got=running expected=done");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
